// File: rtl/acc_serial_unit.sv
// Bit-serial accumulator: load/add/sub/neg/shift-right one digit per clock, LSB first.
// Optional sticky overflow flag and w_A_OVF port are built when ACC_OVERFLOW_EN is defined.
module acc_serial_unit #(
    parameter int LINE_LENGTH         = 40,
    parameter int INSTR_FUNCTION_BITS = 6,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_LDA = 6'b100000,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_ADD = 6'b101100,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SUB = 6'b100110,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_NEG = 6'b110110,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SHR = 6'b111110
) (
    input  logic                           w_CLK,
    input  logic                           w_RST,
    input  logic                           w_PARA_ACTION,
    input  logic [0:INSTR_FUNCTION_BITS-1] b_FST,
    input  logic                           w_ACEG,
    input  logic [0:LINE_LENGTH-1]         b_A_DATA_IN,
    output logic [0:LINE_LENGTH-1]         b_A_OUT,
    output logic                           w_A_SIGN,
    output logic                           w_A_ZERO,
    output logic                           w_A_BUSY,
`ifdef ACC_OVERFLOW_EN
    output logic                           w_A_OVF,
`endif
    output logic                           w_A_DONE
);

    localparam int CW = $clog2(LINE_LENGTH);
    localparam logic [CW-1:0] LAST = CW'(LINE_LENGTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t                         state, state_next;
    logic                           act_low_q;
    logic                           start;
    logic [0:LINE_LENGTH-1]         op_q;
    logic [0:LINE_LENGTH-1]         work_q;
    logic [0:LINE_LENGTH-1]         work_next;
    logic [0:LINE_LENGTH-1]         acc_q;
    logic [0:INSTR_FUNCTION_BITS-1] fst_q;
    logic                           carry_q, carry_next;
    logic [CW-1:0]                  cnt_q;
    logic [CW-1:0]                  shr_idx;
    logic                           is_arith, is_inv, is_shr;
    logic                           o_bit, r_bit;
`ifdef ACC_OVERFLOW_EN
    logic                           ovf_q;
`endif

    // act_low_q remembers "previous sample was low"; resetting it to 1 blocks a start on release.
    assign start = ~act_low_q & ~w_PARA_ACTION;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: if (cnt_q == LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        is_arith   = (fst_q == INST_LDA) || (fst_q == INST_ADD) ||
                     (fst_q == INST_SUB) || (fst_q == INST_NEG);
        is_inv     = (fst_q == INST_SUB) || (fst_q == INST_NEG);
        is_shr     = (fst_q == INST_SHR);
        shr_idx    = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        o_bit      = is_shr ? op_q[shr_idx] : (op_q[cnt_q] ^ is_inv);
        r_bit      = work_q[cnt_q];
        carry_next = carry_q;
        if (is_arith) begin
            r_bit      = work_q[cnt_q] ^ o_bit ^ carry_q;
            carry_next = (work_q[cnt_q] & o_bit) | (work_q[cnt_q] & carry_q) | (o_bit & carry_q);
        end else if (is_shr) begin
            r_bit = o_bit;
        end
        work_next         = work_q;
        work_next[cnt_q]  = r_bit;
    end

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            state     <= S_IDLE;
            act_low_q <= 1'b1;
            op_q      <= '0;
            work_q    <= '0;
            acc_q     <= '0;
            fst_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
`ifdef ACC_OVERFLOW_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            act_low_q <= ~w_PARA_ACTION;
            case (state)
                S_LOAD: begin
                    op_q    <= b_A_DATA_IN;
                    fst_q   <= b_FST;
                    work_q  <= w_ACEG ? '0 : acc_q;
                    carry_q <= (b_FST == INST_SUB) || (b_FST == INST_NEG);
                    cnt_q   <= '0;
                end
                S_SHIFT: begin
                    work_q  <= work_next;
                    carry_q <= carry_next;
                    cnt_q   <= cnt_q + 1'b1;
                    // Commit on the last digit so the new value is visible during DONE.
                    if (cnt_q == LAST) begin
                        acc_q <= work_next;
`ifdef ACC_OVERFLOW_EN
                        if (is_arith && (fst_q != INST_LDA) && (carry_q != carry_next))
                            ovf_q <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign b_A_OUT  = acc_q;
    assign w_A_SIGN = acc_q[LINE_LENGTH-1];
    assign w_A_ZERO = ~|acc_q;
    assign w_A_BUSY = (state == S_LOAD) || (state == S_SHIFT);
    assign w_A_DONE = (state == S_DONE);
`ifdef ACC_OVERFLOW_EN
    assign w_A_OVF  = ovf_q;
`endif

endmodule
